// File: rtl/fifo_word_packer_if.sv
// -----------------------------------------------------------------------------
// fifo_word_packer_if
// Bundles the FIFO read port and the packed-word valid/ready port of
// fifo_word_packer. Signal names keep the packer's point of view (_i = into the
// packer, _o = out of the packer).
//   master : the packer itself
//   slave  : the environment (FIFO read side plus the wide downstream sink)
// -----------------------------------------------------------------------------
interface fifo_word_packer_if #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
);
    localparam int BYTES_W = $clog2(RATIO) + 1;

    // FIFO read side
    logic                   fifo_empty_i;
    logic [WIDTH-1:0]       fifo_rdata_i;
    logic                   fifo_rd_en_o;

    // Packed-word output side
    logic [WIDTH*RATIO-1:0] word_o;
    logic                   word_valid_o;
    logic                   word_ready_i;
    logic [BYTES_W-1:0]     word_bytes_o;

    modport master (
        input  fifo_empty_i,
        input  fifo_rdata_i,
        input  word_ready_i,
        output fifo_rd_en_o,
        output word_o,
        output word_valid_o,
        output word_bytes_o
    );

    modport slave (
        output fifo_empty_i,
        output fifo_rdata_i,
        output word_ready_i,
        input  fifo_rd_en_o,
        input  word_o,
        input  word_valid_o,
        input  word_bytes_o
    );
endinterface

// File: rtl/fifo_word_packer.sv
// -----------------------------------------------------------------------------
// fifo_word_packer
// Read-clock-domain consumer for the async FIFO. Pops WIDTH-bit entries and
// packs RATIO consecutive entries into one little-endian wide word (first
// entry read lands in lane 0), presented on a valid/ready port.
//
// Read latency of the FIFO is one cycle: a read issued in cycle n delivers its
// data in cycle n+1, where it is captured into the next free lane.
//
// Optional feature macro: PACK_FLUSH_EN
//   defined   : a partial word is flushed after TIMEOUT idle cycles, with
//               word_bytes_o giving the number of valid lanes.
//   undefined : partial words wait for more entries; word_bytes_o == RATIO
//               whenever word_valid_o is high.
// -----------------------------------------------------------------------------
module fifo_word_packer #(
    parameter int WIDTH   = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    fifo_word_packer_if.master  bus
);
    localparam int CW = $clog2(RATIO) + 1;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e                       state;
    logic   [CW-1:0]              cnt;        // lanes already captured
    logic                         pend;       // a read was issued last cycle
    logic   [RATIO-1:0][WIDTH-1:0] lanes;     // assembly register
    logic   [CW:0]                inflight;   // captured + still in flight
    logic                         rd_en;
    logic                         slot_free;
    logic                         capture;
    logic                         last_capture;
    logic                         flush;

    assign inflight     = {1'b0, cnt} + {{CW{1'b0}}, pend};
    assign slot_free    = !bus.word_valid_o || bus.word_ready_i;
    assign capture      = pend && (state == FILL);
    assign last_capture = capture && (cnt == CW'(RATIO - 1));

    // Read request: only in FILL, never while empty, never beyond the lanes left.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_en = 1'b0;
        if (!rst_i && !bus.fifo_empty_i && (state == FILL) &&
            (inflight < (CW+1)'(RATIO))) begin
            rd_en = 1'b1;
        end
    end

    assign bus.fifo_rd_en_o = rd_en;

`ifdef PACK_FLUSH_EN
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [IW-1:0] idle_cnt;
    logic          idle_cycle;

    // A partial word is waiting and nothing is arriving or available.
    assign idle_cycle = (state == FILL) && (cnt != '0) && !pend && bus.fifo_empty_i;
    assign flush      = (state == FILL) && (cnt != '0) && !pend &&
                        (idle_cnt == IW'(TIMEOUT)) && slot_free;

    // Idle counter: counts consecutive idle cycles, saturating at TIMEOUT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idle_cnt <= '0;
        end else if (flush || !idle_cycle) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IW'(TIMEOUT)) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end
`else
    logic unused_timeout;

    assign flush          = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Packing FSM: capture lanes in FILL, hand the word to the output slot in FULL.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= FILL;
            cnt              <= '0;
            pend             <= 1'b0;
            // NOTE: the assembly register is reset (and re-cleared on every
            // load) because a flushed partial word must present 0 in its
            // unused upper lanes.
            lanes            <= '0;
            bus.word_o       <= '0;
            bus.word_valid_o <= 1'b0;
            bus.word_bytes_o <= '0;
        end else begin
            pend <= rd_en;

            if (bus.word_valid_o && bus.word_ready_i) begin
                bus.word_valid_o <= 1'b0;
            end

            case (state)
                FILL: begin
                    if (capture) begin
                        for (int i = 0; i < RATIO; i++) begin
                            if (cnt == CW'(i)) begin
                                lanes[i] <= bus.fifo_rdata_i;
                            end
                        end
                        cnt <= cnt + CW'(1);
                        if (last_capture) begin
                            state <= FULL;
                        end
                    end else if (flush) begin
                        bus.word_o       <= lanes;
                        bus.word_valid_o <= 1'b1;
                        bus.word_bytes_o <= cnt;
                        cnt              <= '0;
                        lanes            <= '0;
                    end
                end
                FULL: begin
                    if (slot_free) begin
                        bus.word_o       <= lanes;
                        bus.word_valid_o <= 1'b1;
                        bus.word_bytes_o <= CW'(RATIO);
                        cnt              <= '0;
                        lanes            <= '0;
                        state            <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_word_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_word_packer
// Bench for fifo_word_packer. A queue-based FIFO model feeds the packer; every
// entry the packer pops is appended to a byte list, and each group of RATIO
// bytes becomes an owed word. Whenever word_valid_o is high the output must
// equal the oldest owed word. Directed sequences pin exact values; a random
// phase exercises backpressure and empty toggling.
// Honors PACK_FLUSH_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fifo_word_packer;
    localparam int WIDTH   = 8;
    localparam int RATIO   = 4;
    localparam int TIMEOUT = 16;
    localparam int WW      = WIDTH * RATIO;

    typedef struct {
        logic [WW-1:0] word;
        int            bytes;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_word_packer_if #(.WIDTH(WIDTH), .RATIO(RATIO)) bus ();

    fifo_word_packer #(
        .WIDTH  (WIDTH),
        .RATIO  (RATIO),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // FIFO model and packing model
    logic [WIDTH-1:0] fifo_q[$];
    int               push_total = 0;
    int               pop_total  = 0;
    logic             hide       = 1'b0;
    logic [WIDTH-1:0] acc[$];
    exp_t             exp_q[$];

    assign bus.fifo_empty_i = hide || (push_total == pop_total);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int pending();
        return push_total - pop_total;
    endfunction

    task automatic push(input logic [WIDTH-1:0] b);
        fifo_q.push_back(b);
        push_total++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_word(output logic [WW-1:0] w, output int by);
        bit ok;
        ok = 1'b0;
        w  = '0;
        by = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.word_valid_o) begin
                w  = bus.word_o;
                by = int'(bus.word_bytes_o);
                ok = 1'b1;
                break;
            end
        end
        check("word_within_budget", 64'(ok), 64'd1);
    endtask

    // FIFO read port model; every popped entry goes into the packing model.
    always @(posedge clk) begin : fifo_model
        logic [WIDTH-1:0] b;
        logic [WW-1:0]    w;
        if (rst) begin
            acc.delete();
            exp_q.delete();
        end else if (bus.fifo_rd_en_o) begin
            check("rd_while_empty", 64'(bus.fifo_empty_i), 64'd0);
            check("rd_has_data", 64'(fifo_q.size() != 0), 64'd1);
            if (fifo_q.size() != 0) begin
                b = fifo_q.pop_front();
                bus.fifo_rdata_i <= b;
                pop_total        <= pop_total + 1;
                acc.push_back(b);
                if (acc.size() == RATIO) begin
                    w = '0;
                    for (int i = 0; i < RATIO; i++) w[i*WIDTH +: WIDTH] = acc[i];
                    exp_q.push_back('{word: w, bytes: RATIO});
                    acc.delete();
                end
            end
        end
    end

    // Output compare: a valid word must be the oldest owed word.
    always @(negedge clk) begin
        if (!rst && bus.word_valid_o) begin
            check("word_owed", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check("word_o", 64'(bus.word_o), 64'(exp_q[0].word));
                check("word_bytes_o", 64'(bus.word_bytes_o), 64'(exp_q[0].bytes));
                if (bus.word_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [WW-1:0] w;
    int            by;
    int            rd_hi;
    int            vcnt;
    int            n;
    int            pad;
    bit            seen;
    bit            done;

    initial begin
        rst              = 1'b1;
        bus.word_ready_i = 1'b1;
        bus.fifo_rdata_i = '0;
        hide             = 1'b0;

        // Reset: outputs zero and no read even with a non-empty FIFO.
        tick();
        tick();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        @(negedge clk);
        check("rst_valid", 64'(bus.word_valid_o), 64'd0);
        check("rst_word", 64'(bus.word_o), 64'd0);
        check("rst_bytes", 64'(bus.word_bytes_o), 64'd0);
        check("rst_rd_en", 64'(bus.fifo_rd_en_o), 64'd0);
        tick();
        rst = 1'b0;

        // Back-to-back entries, ready high.
        rd_hi = 0;
        vcnt  = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.fifo_rd_en_o) rd_hi++;
            if (bus.word_valid_o) begin
                vcnt++;
                w  = bus.word_o;
                by = int'(bus.word_bytes_o);
            end
        end
        check("t1_rd_cycles", 64'(rd_hi), 64'd4);
        check("t1_valid_cycles", 64'(vcnt), 64'd1);
        check("t1_word", 64'(w), 64'h44332211);
        check("t1_bytes", 64'(by), 64'd4);

        // Backpressure: first word held, second word assembled, reads stop.
        tick();
        bus.word_ready_i = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (20) @(negedge clk);
        check("t2_held_valid", 64'(bus.word_valid_o), 64'd1);
        check("t2_held_word", 64'(bus.word_o), 64'h04030201);
        check("t2_no_read", 64'(bus.fifo_rd_en_o), 64'd0);
        check("t2_all_consumed", 64'(pending()), 64'd0);
        tick();
        bus.word_ready_i = 1'b1;
        @(negedge clk);
        check("t2_first_valid", 64'(bus.word_valid_o), 64'd1);
        check("t2_first_word", 64'(bus.word_o), 64'h04030201);
        @(negedge clk);
        check("t2_second_valid", 64'(bus.word_valid_o), 64'd1);
        check("t2_second_word", 64'(bus.word_o), 64'h08070605);
        @(negedge clk);
        check("t2_drained", 64'(bus.word_valid_o), 64'd0);

        // Empty flag toggling every cycle.
        tick();
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        seen = 1'b0;
        w    = '0;
        repeat (24) begin
            @(posedge clk);
            #1 hide = ~hide;
            @(negedge clk);
            if (bus.word_valid_o) begin
                seen = 1'b1;
                w    = bus.word_o;
            end
        end
        hide = 1'b0;
        check("t3_seen", 64'(seen), 64'd1);
        check("t3_word", 64'(w), 64'hA3A2A1A0);

        // Reset with two lanes captured and one read in flight.
        tick();
        push(8'hE0); push(8'hE1); push(8'hE2);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t4_rd_in_rst", 64'(bus.fifo_rd_en_o), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t4_valid", 64'(bus.word_valid_o), 64'd0);
        check("t4_word", 64'(bus.word_o), 64'd0);
        check("t4_fifo_drained", 64'(pending()), 64'd0);
        tick();
        push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3);
        wait_word(w, by);
        check("t4_new_word", 64'(w), 64'hC3C2C1C0);
        check("t4_new_bytes", 64'(by), 64'd4);

        // Partial word followed by an empty FIFO.
        tick();
        push(8'hAA); push(8'hBB); push(8'hCC);
`ifdef PACK_FLUSH_EN
        repeat (6) @(posedge clk);
        #1;
        exp_q.push_back('{word: 32'h00CCBBAA, bytes: 3});
        acc.delete();
        n    = 6;
        seen = 1'b0;
        while (n < 60 && !seen) begin
            @(negedge clk);
            if (bus.word_valid_o) begin
                seen = 1'b1;
                w    = bus.word_o;
                by   = int'(bus.word_bytes_o);
            end else begin
                @(posedge clk);
                n++;
            end
        end
        check("t5_flush_seen", 64'(seen), 64'd1);
        check("t5_flush_edge", 64'(n), 64'(TIMEOUT + 5));
        check("t5_flush_word", 64'(w), 64'h00CCBBAA);
        check("t5_flush_bytes", 64'(by), 64'd3);
`else
        vcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.word_valid_o) vcnt++;
        end
        check("t5_no_flush", 64'(vcnt), 64'd0);
        tick();
        push(8'hDD);
        wait_word(w, by);
        check("t5_completed_word", 64'(w), 64'hDDCCBBAA);
        check("t5_completed_bytes", 64'(by), 64'd4);
`endif

        // Random traffic with backpressure and empty toggling.
        for (int c = 0; c < 3000; c++) begin
            tick();
            bus.word_ready_i = ($urandom_range(0, 3) != 0);
            hide             = ($urandom_range(0, 3) == 0);
            if (pending() < 2) begin
                push(8'($urandom)); push(8'($urandom));
            end else if (pending() < 8) begin
                repeat ($urandom_range(0, 1)) push(8'($urandom));
            end
        end
        tick();
        hide             = 1'b0;
        bus.word_ready_i = 1'b1;
        pad = (RATIO - ((acc.size() + pending()) % RATIO)) % RATIO;
        repeat (pad) push(8'($urandom));
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && acc.size() == 0 && pending() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_complete", 64'(done), 64'd1);
        repeat (3) @(negedge clk);
        check("final_idle", 64'(bus.word_valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
